// File: rtl/apb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// apb_ctrl_pkg
// Shared types for the round-robin APB requester.
//   state_t      : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   apb_phase_t  : the PSEL/PENABLE pair driven in each bus phase
//   PHASE_*      : the three legal APB phase encodings
// No ports; imported by apb_rr_master.
// ---------------------------------------------------------------------------
package apb_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef struct packed {
      logic psel;
      logic penable;
   } apb_phase_t;

   localparam apb_phase_t PHASE_IDLE   = '{psel: 1'b0, penable: 1'b0};
   localparam apb_phase_t PHASE_SETUP  = '{psel: 1'b1, penable: 1'b0};
   localparam apb_phase_t PHASE_ACCESS = '{psel: 1'b1, penable: 1'b1};

endpackage

// File: rtl/apb_rr_master_if.sv
// ---------------------------------------------------------------------------
// apb_rr_master_if
// Bundles the client request/response signals and the APB bus of the
// round-robin APB requester.
//   Client side : req_valid, req_write, req_addr, req_wdata (to requester)
//                 req_ready, rsp_valid, rsp_rdata, rsp_err (from requester)
//   APB side    : PADDR, PSEL, PENABLE, PWRITE, PWDATA (from requester)
//                 PRDATA, PREADY, PSLVERR (from completer)
// Modports:
//   master : the requester (apb_rr_master)
//   slave  : the environment (clients plus APB completer)
// ---------------------------------------------------------------------------
interface apb_rr_master_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          rsp_err;

   logic [ADDR_WIDTH-1:0]         PADDR;
   logic                          PSEL;
   logic                          PENABLE;
   logic                          PWRITE;
   logic [DATA_WIDTH-1:0]         PWDATA;
   logic [DATA_WIDTH-1:0]         PRDATA;
   logic                          PREADY;
   logic                          PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: picks the first requesting client after
// the previously granted one, wrapping around to client 0.
// Ports:
//   req_i       in  NUM_REQ  request vector
//   lastGrant_i in  IDX_W    index of the previously granted client
//   grant_o     out NUM_REQ  one-hot grant (all zero when nobody requests)
//   grantIdx_o  out IDX_W    index of the granted client
//   anyReq_o    out 1        at least one client is requesting
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   lastGrant_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   grantIdx_o,
   output logic               anyReq_o
);

   logic [IDX_W-1:0] lowIdx;
   logic [IDX_W-1:0] highIdx;
   logic             highFound;

   // Two descending scans leave the lowest matching index in each result:
   // the lowest requester overall, and the lowest requester above the last
   // grant. The latter wins when it exists, otherwise the search wraps.
   always_comb begin
      lowIdx    = '0;
      highIdx   = '0;
      highFound = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            lowIdx = IDX_W'(i);
            if (IDX_W'(i) > lastGrant_i) begin
               highIdx   = IDX_W'(i);
               highFound = 1'b1;
            end
         end
      end
   end

   always_comb begin
      anyReq_o   = |req_i;
      grantIdx_o = highFound ? highIdx : lowIdx;
      grant_o    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_o[i] = anyReq_o && (grantIdx_o == IDX_W'(i));
      end
   end

endmodule

// File: rtl/apb_rr_master.sv
// ---------------------------------------------------------------------------
// apb_rr_master
// APB requester shared by NUM_REQ local clients. A round-robin arbiter picks
// one client, the FSM runs the APB SETUP and ACCESS phases, then returns read
// data and error status to that client with a one-cycle rsp_valid pulse.
// All outputs are registered.
// Ports:
//   PCLK    in  clock, all logic on the rising edge
//   PRESET  in  synchronous active-high reset
//   bus_io  apb_rr_master_if.master: client request/response and APB bus
// Configuration:
//   APB_TIMEOUT_EN  when defined, an ACCESS phase lasting TIMEOUT_CYCLES
//                   cycles without PREADY is abandoned and reported with
//                   rsp_err=1. When undefined, ACCESS waits for PREADY forever.
// ---------------------------------------------------------------------------
module apb_rr_master
   import apb_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            PCLK,
   input  logic            PRESET,
   apb_rr_master_if.master bus_io
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                state_q,     state_d;
   logic [IDX_W-1:0]      lastGrant_q, lastGrant_d;
   logic [NUM_REQ-1:0]    reqReady_q,  reqReady_d;
   logic [NUM_REQ-1:0]    rspValid_q,  rspValid_d;
   logic [DATA_WIDTH-1:0] rspRdata_q,  rspRdata_d;
   logic                  rspErr_q,    rspErr_d;
   logic                  psel_q;
   logic                  penable_q;
   apb_phase_t            phase_d;
   logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
   logic                  pwrite_q,    pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;

   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      grantIdx;
   logic                  anyReq;
   logic                  tmoHit;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uArbiter (
      .req_i       (bus_io.req_valid),
      .lastGrant_i (lastGrant_q),
      .grant_o     (grant),
      .grantIdx_o  (grantIdx),
      .anyReq_o    (anyReq)
   );

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmoCnt_q;

   // Counts ACCESS cycles without PREADY; cleared whenever we are not in
   // ACCESS so every transfer starts its wait from zero.
   always_ff @(posedge PCLK) begin
      if (PRESET || (state_q != ACCESS)) begin
         tmoCnt_q <= '0;
      end else if (!bus_io.PREADY) begin
         tmoCnt_q <= tmoCnt_q + TMO_W'(1);
      end
   end

   // Fires on the last allowed ACCESS cycle; a PREADY in that same cycle
   // still completes the transfer normally.
   assign tmoHit = (state_q == ACCESS) && !bus_io.PREADY &&
                   (tmoCnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmoHit = 1'b0;
`endif

   // State and output registers. Reset parks the FSM in IDLE with the last
   // grant on the highest client so client 0 wins the first arbitration.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= IDLE;
         lastGrant_q <= IDX_W'(NUM_REQ - 1);
         reqReady_q  <= '0;
         rspValid_q  <= '0;
         rspRdata_q  <= '0;
         rspErr_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         reqReady_q  <= reqReady_d;
         rspValid_q  <= rspValid_d;
         rspRdata_q  <= rspRdata_d;
         rspErr_q    <= rspErr_d;
         psel_q      <= phase_d.psel;
         penable_q   <= phase_d.penable;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
      end
   end

   // Next-state logic: one pass through SETUP and RESP per transfer, ACCESS
   // held until the completer answers or the optional timeout expires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (anyReq) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (bus_io.PREADY || tmoHit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: computes the registered outputs for the state being
   // entered. Payload registers hold their value in IDLE so the bus never
   // shows X between transfers.
   always_comb begin
      lastGrant_d = lastGrant_q;
      reqReady_d  = '0;
      rspValid_d  = '0;
      rspRdata_d  = '0;
      rspErr_d    = 1'b0;
      phase_d     = PHASE_IDLE;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               reqReady_d  = grant;
               lastGrant_d = grantIdx;
               phase_d     = PHASE_SETUP;
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (grant[i]) begin
                     paddr_d  = bus_io.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                     pwrite_d = bus_io.req_write[i];
                     pwdata_d = bus_io.req_write[i] ?
                                bus_io.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                  end
               end
            end
         end
         SETUP: begin
            phase_d = PHASE_ACCESS;
         end
         ACCESS: begin
            if (bus_io.PREADY) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  rspValid_d[i] = (lastGrant_q == IDX_W'(i));
               end
               rspErr_d   = bus_io.PSLVERR;
               rspRdata_d = (!pwrite_q && !bus_io.PSLVERR) ? bus_io.PRDATA : '0;
            end else if (tmoHit) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  rspValid_d[i] = (lastGrant_q == IDX_W'(i));
               end
               rspErr_d = 1'b1;
            end else begin
               phase_d = PHASE_ACCESS;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus_io.req_ready = reqReady_q;
   assign bus_io.rsp_valid = rspValid_q;
   assign bus_io.rsp_rdata = rspRdata_q;
   assign bus_io.rsp_err   = rspErr_q;
   assign bus_io.PADDR     = paddr_q;
   assign bus_io.PSEL      = psel_q;
   assign bus_io.PENABLE   = penable_q;
   assign bus_io.PWRITE    = pwrite_q;
   assign bus_io.PWDATA    = pwdata_q;

endmodule
